// File: rtl/imm_encoder.sv
// Instruction-word encoder: packs a field bundle into a 32-bit word by opcode format,
// range-checks the immediate, and emits words with sequential write addresses.
module imm_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [3:0]        funct,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clear,
  output logic [15:0]       count,
  output logic              dbg_state
);

  // Handshakes: a bundle is taken on an edge with in_valid && in_ready; a word is
  // delivered on an edge with out_valid && out_ready. Neither side may retract early.

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [5:0] OP_ITYPE  = 6'b010011;
  localparam logic [5:0] OP_LOAD   = 6'b000011;
  localparam logic [5:0] OP_STORE  = 6'b100011;
  localparam logic [5:0] OP_BRANCH = 6'b000100;
  localparam logic [5:0] OP_MAC    = 6'b000111;
  localparam logic [5:0] OP_JUMP   = 6'b000010;
  localparam logic [5:0] OP_FSJ    = 6'b111001;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_out_valid;
  logic [31:0]         r_out_instr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [ADDR_W-1:0]   r_next_addr;
  logic [15:0]         r_count;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_known;
  logic                w_accept;
  logic                w_deliver;
  logic                w_in_ready;
  logic                w_imm12_ok;
  logic                w_imm26_ok;
  logic                w_fsj_ok;
  logic [ADDR_W-1:0]   w_addr_sel;

  // Signed-range checks: every bit above the sign bit must replicate it.
  assign w_imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_imm26_ok = (&imm[31:25]) | ~(|imm[31:25]);
  assign w_fsj_ok   = (imm[31:24] == {8{imm[23]}}) && (imm[15:8] == {8{imm[7]}});

  always_comb begin
    w_word        = '0;
    w_word[31:26] = opcode;
    w_legal       = 1'b0;
    w_known       = 1'b1;
    case (opcode)
      OP_ITYPE, OP_LOAD: begin
        w_word[25:21] = rs1;
        w_word[20:16] = rd;
        w_word[15:4]  = imm[11:0];
        w_word[3:0]   = funct;
        w_legal       = w_imm12_ok;
      end
      OP_STORE, OP_BRANCH: begin
        w_word[25:21] = imm[11:7];
        w_word[20:16] = rs1;
        w_word[15:11] = rs2;
        w_word[10:4]  = imm[6:0];
        w_word[3:0]   = funct;
        w_legal       = w_imm12_ok;
      end
      OP_MAC: begin
        w_word[25:21] = rd;
        w_word[20:16] = rs1;
        w_word[15:11] = rs2;
        w_word[5:0]   = imm[5:0];
        w_legal       = ~(|imm[31:6]);
      end
      OP_JUMP: begin
        w_word[25:0]  = imm[25:0];
        w_legal       = w_imm26_ok;
      end
      OP_FSJ: begin
        w_word[25:21] = imm[23:19];
        w_word[20:16] = rs1;
        w_word[15:11] = rs2;
        w_word[10:8]  = imm[18:16];
        w_word[7:0]   = imm[7:0];
        w_legal       = w_fsj_ok;
      end
      default: w_known = 1'b0;
    endcase
  end

  assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_deliver  = r_out_valid && out_ready;
  // A same-edge start supplies the address for the bundle taken with it.
  assign w_addr_sel = start ? base_addr : r_next_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_accept && !w_legal) w_state_nxt = ST_HALT;
      ST_HALT: if (err_clear) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
      r_next_addr <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      if (w_deliver) r_out_valid <= 1'b0;
      if (start)     r_next_addr <= base_addr;
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_word;
        r_out_addr  <= w_addr_sel;
        r_next_addr <= w_addr_sel + ADDR_W'(4);
      end
      if (start)          r_count <= '0;
      else if (w_deliver) r_count <= r_count + 16'd1;
      if (w_accept && !w_legal) begin
        r_err      <= 1'b1;
        r_err_code <= w_known ? 2'b01 : 2'b10;
      end else if ((r_state == ST_HALT) && err_clear) begin
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed scenarios plus randomized traffic checked against
// an arithmetic encoding model and a one-deep expected-word queue.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready, err_clear;
  logic [11:0] base_addr;
  logic [5:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  funct;
  logic [31:0] imm;

  logic        in_ready, out_valid, err, dbg_state;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic [1:0]  err_code;
  logic [15:0] count;

  logic        in_ready4, out_valid4, err4, dbg_state4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [1:0]  err_code4;
  logic [15:0] count4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [11:0] addr_q[$];
  logic [11:0] m_next;
  logic [15:0] m_count;
  logic        m_halt;
  logic [1:0]  m_code;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_W(12)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct(funct), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_code(err_code), .err_clear(err_clear), .count(count),
    .dbg_state(dbg_state));

  imm_encoder #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr[3:0]),
    .in_valid(in_valid), .in_ready(in_ready4), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct(funct), .imm(imm), .out_valid(out_valid4),
    .out_ready(out_ready), .out_instr(out_instr4), .out_addr(out_addr4),
    .err(err4), .err_code(err_code4), .err_clear(err_clear), .count(count4),
    .dbg_state(dbg_state4));

  function automatic void model_encode(input logic [5:0] op, input logic [4:0] f_rd,
      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [3:0] fn,
      input logic [31:0] v, output bit ok, output logic [1:0] code, output logic [31:0] w);
    int s;
    s    = $signed(v);
    w    = 32'(op) << 26;
    ok   = 1'b1;
    code = 2'b00;
    case (op)
      6'b010011, 6'b000011: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = w | (32'(f_rs1) << 21) | (32'(f_rd) << 16) | ((v & 32'hFFF) << 4) | 32'(fn);
      end
      6'b100011, 6'b000100: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = w | (((v >> 7) & 32'h1F) << 21) | (32'(f_rs1) << 16) | (32'(f_rs2) << 11)
               | ((v & 32'h7F) << 4) | 32'(fn);
      end
      6'b000111: begin
        ok = (v <= 32'd63);
        w  = w | (32'(f_rd) << 21) | (32'(f_rs1) << 16) | (32'(f_rs2) << 11) | (v & 32'h3F);
      end
      6'b000010: begin
        ok = (s >= -33554432) && (s <= 33554431);
        w  = w | (v & 32'h03FF_FFFF);
      end
      6'b111001: begin
        ok = (((s >>> 23) == 0) || ((s >>> 23) == -1)) &&
             ((((v >> 7) & 32'h1FF) == 32'h0) || (((v >> 7) & 32'h1FF) == 32'h1FF));
        w  = w | (((v >> 19) & 32'h1F) << 21) | (32'(f_rs1) << 16) | (32'(f_rs2) << 11)
               | (((v >> 16) & 32'h7) << 8) | (v & 32'hFF);
      end
      default: begin
        ok   = 1'b0;
        code = 2'b10;
      end
    endcase
    if (!ok && code == 2'b00) code = 2'b01;
  endfunction

  // Model of one clock edge, evaluated with the inputs that are stable before it.
  task automatic model_edge();
    bit acc, dlv, ok;
    logic [1:0]  code;
    logic [31:0] w;
    acc = in_valid && !m_halt && (exp_q.size() == 0 || out_ready);
    dlv = (exp_q.size() != 0) && out_ready;
    if (dlv) begin
      void'(exp_q.pop_front());
      void'(addr_q.pop_front());
      m_count = m_count + 16'd1;
    end
    if (start) begin
      m_count = 16'd0;
      m_next  = base_addr;
    end
    if (acc) begin
      model_encode(opcode, rd, rs1, rs2, funct, imm, ok, code, w);
      if (ok) begin
        exp_q.push_back(w);
        addr_q.push_back(m_next);
        m_next = m_next + 12'd4;
      end else begin
        m_halt = 1'b1;
        m_code = code;
      end
    end else if (m_halt && err_clear) begin
      m_halt = 1'b0;
      m_code = 2'b00;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    addr_q.delete();
    m_next  = '0;
    m_count = '0;
    m_halt  = 1'b0;
    m_code  = 2'b00;
  endtask

  task automatic idle_inputs();
    start = 0; base_addr = '0; in_valid = 0; out_ready = 0; err_clear = 0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct = '0; imm = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [5:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                            input logic [4:0] f_rs2, input logic [3:0] fn, input logic [31:0] v);
    in_valid = 1'b1; opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; funct = fn; imm = v;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: t = 32'(int'($urandom_range(0, 4200)) - 2100);
      1: t = 32'($urandom_range(0, 70));
      2: t = $urandom();
      3: begin
        t = $urandom();
        t[31:24] = {8{t[23]}};
        if ($urandom_range(0, 1) == 1) t[15:8] = {8{t[7]}};
      end
      4: t = 32'(int'($urandom_range(0, 16)) - 8 + (($urandom_range(0, 1) == 1) ? 33554432 : -33554432));
      default: t = 32'($urandom_range(0, 15));
    endcase
    return t;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
    n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h exp 0", out_instr); end
    n_tests++; if (out_addr !== 12'h0) begin n_fail++; $display("FAIL reset_out_addr: got %h exp 0", out_addr); end
    n_tests++; if (count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_tests++; if (err !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %0b/%b exp 0/00", err, err_code); end
    n_tests++; if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_run: in_ready %0b state %0b exp 1/0", in_ready, dbg_state); end
    do_reset();
  endtask

  task automatic test_itype();
    do_reset();
    start = 1; base_addr = 12'h100;
    set_bundle(6'b010011, 5'd3, 5'd2, 5'd0, 4'd5, 32'hFFFF_FFFF);
    tick();
    start = 0; in_valid = 0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL itype_valid: got %0b exp 1", out_valid); end
    n_tests++; if (out_instr !== 32'h4C43FFF5) begin n_fail++; $display("FAIL itype_instr: got %h exp 4c43fff5", out_instr); end
    n_tests++; if (out_addr !== 12'h100) begin n_fail++; $display("FAIL itype_addr: got %h exp 100", out_addr); end
  endtask

  task automatic test_store();
    do_reset();
    start = 1; base_addr = 12'h100; out_ready = 1;
    set_bundle(6'b100011, 5'd0, 5'd1, 5'd4, 4'd0, 32'h0000_07F5);
    tick();
    start = 0; in_valid = 0;
    n_tests++; if (out_instr !== 32'h8DE12750) begin n_fail++; $display("FAIL store_instr: got %h exp 8de12750", out_instr); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL store_count0: got %0d exp 0", count); end
    tick();
    n_tests++; if (count !== 16'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL store_delivered: count %0d valid %0b exp 1/0", count, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w1;
    do_reset();
    start = 1; base_addr = 12'h100;
    tick();
    start = 0;
    set_bundle(6'b010011, 5'd1, 5'd1, 5'd0, 4'd1, 32'd11);
    tick();
    w1 = exp_q[0];
    set_bundle(6'b000011, 5'd2, 5'd2, 5'd0, 4'd2, 32'd22);
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b exp 0", in_ready); end
      n_tests++; if (out_instr !== w1 || out_addr !== 12'h100) begin n_fail++; $display("FAIL bp_hold: got %h@%h exp %h@100", out_instr, out_addr, w1); end
      tick();
    end
    out_ready = 1;
    tick();
    n_tests++; if (out_addr !== 12'h104 || count !== 16'd1) begin n_fail++; $display("FAIL bp_second: addr %h count %0d exp 104/1", out_addr, count); end
    set_bundle(6'b000100, 5'd0, 5'd3, 5'd3, 4'd3, 32'hFFFF_F800);
    tick();
    n_tests++; if (out_addr !== 12'h108 || count !== 16'd2) begin n_fail++; $display("FAIL bp_third: addr %h count %0d exp 108/2", out_addr, count); end
    n_tests++; if (out_instr !== exp_q[0]) begin n_fail++; $display("FAIL bp_third_instr: got %h exp %h", out_instr, exp_q[0]); end
    in_valid = 0;
    tick();
    n_tests++; if (count !== 16'd3 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: count %0d valid %0b exp 3/0", count, out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1; base_addr = 12'hFF8; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      set_bundle(6'b000010, 5'd0, 5'd0, 5'd0, 4'd0, 32'(i * 1000 - 2000));
      tick();
      start = 0;
      n_tests++; if (out_valid !== 1'b1 || out_instr !== exp_q[0] || out_addr !== addr_q[0]) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h@%h exp %h@%h", i, out_instr, out_addr, exp_q[0], addr_q[0]); end
      n_tests++; if (count !== 16'(i)) begin n_fail++; $display("FAIL b2b_count%0d: got %0d exp %0d", i, count, i); end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_errors();
    do_reset();
    set_bundle(6'b000111, 5'd1, 5'd1, 5'd1, 4'd0, 32'd64);
    tick();
    in_valid = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || err !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL mac_err: valid %0b err %0b code %b exp 0/1/01", out_valid, err, err_code); end
    n_tests++; if (in_ready !== 1'b0 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL mac_halt: in_ready %0b state %0b exp 0/1", in_ready, dbg_state); end
    err_clear = 1;
    tick();
    err_clear = 0;
    n_tests++; if (err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mac_clear: err %0b code %b ready %0b exp 0/00/1", err, err_code, in_ready); end
    set_bundle(6'b111111, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0);
    tick();
    in_valid = 0;
    n_tests++; if (err !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL unknown_op: err %0b code %b exp 1/10", err, err_code); end
    err_clear = 1;
    tick();
    err_clear = 0;
    set_bundle(6'b111001, 5'd0, 5'd0, 5'd0, 4'd0, 32'h0080_0080);
    tick();
    in_valid = 0;
    n_tests++; if (err_code !== 2'b01 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fsj_bad: code %b valid %0b exp 01/0", err_code, out_valid); end
    err_clear = 1;
    tick();
    err_clear = 0;
    set_bundle(6'b111001, 5'd0, 5'd0, 5'd0, 4'd0, 32'hFF80_FF80);
    tick();
    in_valid = 0;
    n_tests++; if (out_instr[25:21] !== 5'h10 || out_instr[10:8] !== 3'd0 || out_instr[7:0] !== 8'h80) begin
      n_fail++; $display("FAIL fsj_good_fields: got %h", out_instr); end
    n_tests++; if (out_instr !== 32'hE600_0080) begin n_fail++; $display("FAIL fsj_good_word: got %h exp e6000080", out_instr); end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    start = 1; base_addr = 12'h00C; out_ready = 1;
    set_bundle(6'b010011, 5'd1, 5'd1, 5'd0, 4'd0, 32'd5);
    tick();
    start = 0;
    n_tests++; if (out_addr4 !== 4'hC) begin n_fail++; $display("FAIL wrap_first: got %h exp c", out_addr4); end
    tick();
    in_valid = 0;
    n_tests++; if (out_addr4 !== 4'h0) begin n_fail++; $display("FAIL wrap_second: got %h exp 0", out_addr4); end
    n_tests++; if (out_addr !== 12'h010) begin n_fail++; $display("FAIL wrap_wide: got %h exp 010", out_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1;
    set_bundle(6'b010011, 5'd1, 5'd1, 5'd0, 4'd0, 32'd1);
    tick();
    tick();
    in_valid = 0; out_ready = 0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || count !== 16'd1) begin n_fail++; $display("FAIL mid_setup: valid %0b count %0d exp 1/1", out_valid, count); end
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL mid_reset: valid %0b count %0d exp 0/0", out_valid, count); end
    do_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    bit m_ready;
    ops = '{6'b010011, 6'b000011, 6'b100011, 6'b000100, 6'b000111, 6'b000010, 6'b111001};
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 40) == 0);
      base_addr = 12'($urandom());
      err_clear = ($urandom_range(0, 5) == 0);
      opcode    = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 6)];
      rd = 5'($urandom()); rs1 = 5'($urandom()); rs2 = 5'($urandom());
      funct = 4'($urandom()); imm = rand_imm();
      @(negedge clk);
      m_ready = !m_halt && (exp_q.size() == 0 || out_ready);
      n_tests++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %0b exp %0b", c, in_ready, m_ready); end
      model_edge();
      @(posedge clk);
      #1;
      n_tests++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %0b exp %0d", c, out_valid, exp_q.size()); end
      if (exp_q.size() != 0) begin
        n_tests++; if (out_instr !== exp_q[0] || out_addr !== addr_q[0]) begin
          n_fail++; $display("FAIL rnd_word c%0d: got %h@%h exp %h@%h", c, out_instr, out_addr, exp_q[0], addr_q[0]); end
      end
      n_tests++; if (count !== m_count) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d exp %0d", c, count, m_count); end
      n_tests++; if (err !== m_halt || err_code !== m_code) begin n_fail++; $display("FAIL rnd_err c%0d: got %0b/%b exp %0b/%b", c, err, err_code, m_halt, m_code); end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_itype();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_errors();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
